rf_writeback_arbiter: RTL and testbench

- Owns the single write port of the 32x32 register file.
- After reset, sequences a deterministic initialisation pass that writes register i with value i.
- Then arbitrates the write port between two writeback requesters: req0 (ALU path, primary) and req1 (load/multi-cycle unit, secondary).
- Sits between the execute/memory writeback sources and the register file write inputs (write enable, write address, write data).

---
 rtl/rf_ctrl_pkg.sv | 17 +
 rtl/rf_init_sequencer.sv | 53 +++++
 rtl/rf_writeback_arbiter.sv | 116 +++++++++++
 tb/tb_rf_writeback_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file write-port control slice.
// Optional feature macro: RF_ZERO_GUARD_EN (suppresses RUN-state writes to register 0).
package rf_ctrl_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_e;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_REQ0 = 2'd1;
  localparam logic [1:0] GNT_REQ1 = 2'd2;

endpackage

// File: rtl/rf_init_sequencer.sv
// Post-reset initialisation counter: walks init_cnt over every register once,
// then moves to RUN and raises init_done on the edge that drives the last register.
module rf_init_sequencer
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  output rf_state_e         state,
  output logic [ADDR_W-1:0] init_cnt,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_done_q, init_done_d;

  // Next-state: advance the counter in INIT; leave INIT after the last register.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == LAST_ADDR) begin
        state_d     = RUN;
        init_done_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign state     = state_q;
  assign init_cnt  = init_cnt_q;
  assign init_done = init_done_q;

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Register-file write-port owner: drives the init pass, then arbitrates between
// req0 (primary) and req1 (secondary, starvation-protected via wait_cnt).
// Optional feature macro: RF_ZERO_GUARD_EN (RUN-state writes to addr 0 are dropped).
module rf_writeback_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned ADDR_W       = RF_ADDR_W,
  parameter int unsigned DATA_W       = RF_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  rf_state_e         state;
  logic [ADDR_W-1:0] init_cnt;

  logic              force1;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  rf_init_sequencer #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_init_seq (
    .clk       (clk),
    .reset     (reset),
    .state     (state),
    .init_cnt  (init_cnt),
    .init_done (init_done)
  );

  // Readies depend only on state, wait_cnt and req0_valid; the two grants are mutually exclusive.
  always_comb begin
    force1     = (wait_cnt_q == LIMIT);
    req0_ready = (state == RUN) && !force1;
    req1_ready = (state == RUN) && (force1 || !req0_valid);
    grant      = GNT_NONE;
    if (req0_valid && req0_ready)      grant = GNT_REQ0;
    else if (req1_valid && req1_ready) grant = GNT_REQ1;
    sel_addr = (grant == GNT_REQ1) ? req1_addr : req0_addr;
    sel_data = (grant == GNT_REQ1) ? req1_data : req0_data;
  end

  // Starvation counter: count denied req1 cycles, saturating at the limit.
  always_comb begin
    wait_cnt_d = '0;
    if ((state == RUN) && req1_valid && !req1_ready)
      wait_cnt_d = (wait_cnt_q == LIMIT) ? LIMIT : wait_cnt_q + 4'd1;
  end

  // Write-port next value: init pattern in INIT, granted request in RUN, else hold addr/data.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (state == INIT) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = init_cnt;
      rf_wdata_d = DATA_W'(init_cnt);
    end else if (grant != GNT_NONE) begin
`ifdef RF_ZERO_GUARD_EN
      if (sel_addr != '0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = sel_addr;
        rf_wdata_d = sel_data;
      end
`else
      rf_we_d    = 1'b1;
      rf_waddr_d = sel_addr;
      rf_wdata_d = sel_data;
`endif
    end
  end

  // Output and arbitration registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: init pass, arbitration table, resets.
module tb_rf_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]  req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready, rf_we, init_done;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  rf_writeback_arbiter #(
    .NUM_REGS     (32),
    .ADDR_W       (5),
    .DATA_W       (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        e_r0;
    logic        e_r1;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rf_we"},     {31'd0, rf_we},      32'd0);
    check({tag, " rf_waddr"},  {27'd0, rf_waddr},   32'd0);
    check({tag, " rf_wdata"},  rf_wdata,            32'd0);
    check({tag, " init_done"}, {31'd0, init_done},  32'd0);
    check({tag, " req0_ready"},{31'd0, req0_ready}, 32'd0);
    check({tag, " req1_ready"},{31'd0, req1_ready}, 32'd0);
  endtask

  // Starts at a negedge just after reset release; ends at a negedge.
  task automatic run_init(input int unsigned steps);
    for (int unsigned i = 0; i < steps; i++) begin
      #1;
      check("init req0_ready", {31'd0, req0_ready}, 32'd0);
      check("init req1_ready", {31'd0, req1_ready}, 32'd0);
      check("init done_early", {31'd0, init_done},  32'd0);
      @(posedge clk); #1;
      check("init rf_we",     {31'd0, rf_we},     32'd1);
      check("init rf_waddr",  {27'd0, rf_waddr},  i);
      check("init rf_wdata",  rf_wdata,           i);
      check("init init_done", {31'd0, init_done}, (i == 31) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
  endtask

  function automatic vec_t mk(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                              input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                              input logic r0, input logic r1, input logic we,
                              input logic [4:0] ea, input logic [31:0] ed);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.e_r0 = r0; v.e_r1 = r1; v.e_we = we; v.e_addr = ea; v.e_data = ed;
    return v;
  endfunction

  initial begin
    // Stimulus/expectation table, applied from RUN with wait_cnt = 0.
    //                    v0 a0  d0            v1 a1  d1           r0 r1 we addr data
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            1, 1, 0, 31, 31));
    vecs.push_back(mk(1, 3,  32'hA5A5A5A5, 1, 4,  32'h1234,     1, 0, 1, 3,  32'hA5A5A5A5));
    vecs.push_back(mk(0, 0,  0,            1, 4,  32'h1234,     1, 1, 1, 4,  32'h1234));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            1, 1, 0, 4,  32'h1234));
    vecs.push_back(mk(1, 7,  1,            0, 0,  0,            1, 0, 1, 7,  1));
    vecs.push_back(mk(1, 7,  2,            0, 0,  0,            1, 0, 1, 7,  2));
    // Starvation: req1 denied four cycles, forced on the fifth.
    vecs.push_back(mk(1, 10, 100,          1, 20, 32'hBEEF,     1, 0, 1, 10, 100));
    vecs.push_back(mk(1, 11, 101,          1, 20, 32'hBEEF,     1, 0, 1, 11, 101));
    vecs.push_back(mk(1, 12, 102,          1, 20, 32'hBEEF,     1, 0, 1, 12, 102));
    vecs.push_back(mk(1, 13, 103,          1, 20, 32'hBEEF,     1, 0, 1, 13, 103));
    vecs.push_back(mk(1, 14, 104,          1, 20, 32'hBEEF,     0, 1, 1, 20, 32'hBEEF));
    vecs.push_back(mk(1, 14, 104,          1, 21, 32'hCAFE,     1, 0, 1, 14, 104));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            1, 1, 0, 14, 104));
    // Forced cycle where req1 has dropped: nothing written, req0 stalled.
    vecs.push_back(mk(1, 1,  1,            1, 2,  2,            1, 0, 1, 1,  1));
    vecs.push_back(mk(1, 1,  1,            1, 2,  2,            1, 0, 1, 1,  1));
    vecs.push_back(mk(1, 1,  1,            1, 2,  2,            1, 0, 1, 1,  1));
    vecs.push_back(mk(1, 1,  1,            1, 2,  2,            1, 0, 1, 1,  1));
    vecs.push_back(mk(1, 5,  5,            0, 0,  0,            0, 1, 0, 1,  1));
    vecs.push_back(mk(1, 5,  5,            0, 0,  0,            1, 0, 1, 5,  5));
    // Register 0 write from req1.
`ifdef RF_ZERO_GUARD_EN
    vecs.push_back(mk(0, 0,  0,            1, 0,  32'hFF,       1, 1, 0, 5,  5));
`else
    vecs.push_back(mk(0, 0,  0,            1, 0,  32'hFF,       1, 1, 1, 0,  32'hFF));
`endif

    // Power-on reset.
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b1;
    run_init(32);

    // Table-driven RUN phase.
    foreach (vecs[k]) begin
      req0_valid = vecs[k].v0; req0_addr = vecs[k].a0; req0_data = vecs[k].d0;
      req1_valid = vecs[k].v1; req1_addr = vecs[k].a1; req1_data = vecs[k].d1;
      #1;
      check($sformatf("vec%0d req0_ready", k), {31'd0, req0_ready}, {31'd0, vecs[k].e_r0});
      check($sformatf("vec%0d req1_ready", k), {31'd0, req1_ready}, {31'd0, vecs[k].e_r1});
      @(posedge clk); #1;
      check($sformatf("vec%0d rf_we", k),    {31'd0, rf_we},    {31'd0, vecs[k].e_we});
      check($sformatf("vec%0d rf_waddr", k), {27'd0, rf_waddr}, {27'd0, vecs[k].e_addr});
      check($sformatf("vec%0d rf_wdata", k), rf_wdata,          vecs[k].e_data);
      check($sformatf("vec%0d init_done", k), {31'd0, init_done}, 32'd1);
      @(negedge clk);
    end

    // Mid-run reset with a request pending: everything clears at once.
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'd9;
    #1;
    reset = 1'b0;
    #1;
    check_reset_outputs("run_rst");
    @(posedge clk); #1;
    check_reset_outputs("run_rst_hold");
    drive_idle();
    @(negedge clk);
    reset = 1'b1;

    // Partial init, then reset during the 10th INIT cycle.
    run_init(9);
    @(posedge clk); #1;
    check("mid rf_waddr", {27'd0, rf_waddr}, 32'd9);
    reset = 1'b0;
    #1;
    check_reset_outputs("init_rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset_outputs("init_rst_hold");
    @(negedge clk);
    reset = 1'b1;
    run_init(32);

    // After init with no requests the write enable drops.
    #1;
    check("post rf_we_pre", {31'd0, rf_we}, 32'd1);
    @(posedge clk); #1;
    check("post rf_we", {31'd0, rf_we}, 32'd0);
    check("post rf_waddr", {27'd0, rf_waddr}, 32'd31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
